// File: rtl/uart_pkg.sv
// uart_pkg: byte width and drain FSM states shared by the UART TX/RX buffers
package uart_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} tx_state_e;
endpackage

// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: host push handshake, status and transmitter-side signals
interface uart_tx_buffer_if import uart_pkg::*; #(parameter int DEPTH = 16);
    logic [BYTE_W-1:0]      wr_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic                   flush;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [BYTE_W-1:0]      tx_data;
    logic                   tx_wr_en;
    logic                   tx_rdy;
    modport slave (input wr_data, wr_valid, flush, tx_rdy,
                   output wr_ready, count, overflow, tx_data, tx_wr_en);
    modport master (output wr_data, wr_valid, flush, tx_rdy,
                    input wr_ready, count, overflow, tx_data, tx_wr_en);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with registered count and flush
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              do_push, do_pop;

    assign full_o    = count_q == (ADDR_W+1)'(DEPTH);
    assign empty_o   = count_q == '0;
    assign do_push   = push_i && !full_o && !flush_i;
    assign do_pop    = pop_i && !empty_o && !flush_i;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // storage is written on accepted pushes only and is never reset
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;

    // pointers wrap naturally at DEPTH; flush wins over a same-cycle push/pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
        end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO drained one byte at a time into a UART transmitter
module uart_tx_buffer import uart_pkg::*; #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input logic               clk,
    input logic               rst_n,
    uart_tx_buffer_if.slave   bus
);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    tx_state_e         state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [BYTE_W-1:0] tx_data_q, fifo_rd_data;
    logic              tx_wr_en_q, overflow_q, pop, full, empty;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (bus.wr_valid),
        .pop_i     (pop),
        .flush_i   (bus.flush),
        .wr_data_i (bus.wr_data),
        .rd_data_o (fifo_rd_data),
        .count_o   (bus.count),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign bus.wr_ready = !full;
    assign bus.overflow = overflow_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_wr_en = tx_wr_en_q;

    // drain FSM: pop on IDLE->ISSUE, pulse once, then wait for the transmitter
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty && bus.tx_rdy) begin
                state_d = ISSUE;
                pop     = 1'b1;
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                tmr_d   = '0;
            end
            WAIT_BUSY:
                if (!bus.tx_rdy) state_d = WAIT_DONE;
                else if (tmr_q == TMR_W'(BUSY_TIMEOUT - 1)) state_d = IDLE;
                else tmr_d = tmr_q + 1'b1;
            WAIT_DONE: if (bus.tx_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // registered FSM state, strobe, held output byte and sticky overflow
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            tx_wr_en_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            tx_wr_en_q <= state_d == ISSUE;
            if (pop) tx_data_q <= fifo_rd_data;
            overflow_q <= bus.flush ? 1'b0 : overflow_q | (bus.wr_valid && full);
        end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed vector table plus multi-cycle sequences with a transmitter model
module tb_uart_tx_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_buffer_if #(.DEPTH(16)) bus();
    uart_tx_buffer #(.DEPTH(16), .BUSY_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic       wv;
        logic [7:0] d;
        logic       fl;
        logic       rdy;
        int         cnt;
        logic       wrdy;
        logic       ovf;
        logic       en;
        logic [7:0] txd;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int consec = 0;
    int busy = 0;
    logic man_rdy = 1'b1;
    logic mdl_rdy = 1'b1;
    logic model_on = 1'b0;
    logic never_busy = 1'b0;
    logic rand_busy = 1'b0;
    int busy_len = 20;
    logic prev_en = 1'b0;
    logic [7:0] rx_q[$];
    int rx_t[$];

    assign bus.tx_rdy = model_on ? mdl_rdy : man_rdy;

    always @(posedge clk) cyc <= cyc + 1;

    // transmitter model and strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0;
            mdl_rdy = 1'b1;
            prev_en = 1'b0;
        end else begin
            if (bus.tx_wr_en) begin
                rx_q.push_back(bus.tx_data);
                rx_t.push_back(cyc);
                if (prev_en) consec++;
                if (model_on && !never_busy) begin
                    busy = rand_busy ? int'($urandom_range(1, 30)) : busy_len;
                    mdl_rdy = 1'b0;
                end
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) mdl_rdy = 1'b1;
            end
            prev_en = bus.tx_wr_en;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int lim);
        for (int i = 0; i < lim && rx_q.size() < n; i++) @(negedge clk);
        chk("rx_count", rx_q.size(), n);
    endtask

    vec_t vt[17];
    int base;
    int sent;
    logic ok_rdy;

    initial begin
        vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 8'hA5};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vt[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vt[5]  = '{1'b1, 8'h7E, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'hA5};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 8'h3C};
        vt[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h3C};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h3C};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h3C};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h3C};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h3C};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 8'h7E};
        vt[13] = '{1'b1, 8'h99, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h7E};
        vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h7E};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h7E};
        vt[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h7E};

        bus.wr_valid = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset state and 50 idle cycles with the transmitter ready
        chk("rst_count", int'(bus.count), 0);
        chk("rst_wr_ready", int'(bus.wr_ready), 1);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);
        base = rx_q.size();
        repeat (50) @(negedge clk);
        chk("idle_pulses", rx_q.size(), base);

        // asynchronous reset while a byte is being issued
        bus.wr_valid = 1'b1;
        bus.wr_data = 8'h55;
        @(negedge clk);
        bus.wr_data = 8'h66;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("pre_rst_en", int'(bus.tx_wr_en), 1);
        chk("pre_rst_count", int'(bus.count), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", int'(bus.tx_wr_en), 0);
        chk("mid_rst_count", int'(bus.count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // vector table: single byte latency, WAIT_DONE path, timeout path, flush
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.wr_valid = vt[i].wv;
            bus.wr_data = vt[i].d;
            bus.flush = vt[i].fl;
            man_rdy = vt[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_count", i), int'(bus.count), vt[i].cnt);
            chk($sformatf("row%0d_wr_ready", i), int'(bus.wr_ready), int'(vt[i].wrdy));
            chk($sformatf("row%0d_overflow", i), int'(bus.overflow), int'(vt[i].ovf));
            chk($sformatf("row%0d_tx_wr_en", i), int'(bus.tx_wr_en), int'(vt[i].en));
            chk($sformatf("row%0d_tx_data", i), int'(bus.tx_data), int'(vt[i].txd));
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.flush = 1'b0;

        // overflow with transmitter held busy, then flush
        man_rdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data = 8'(8'h20 + i);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        chk("ovf_count", int'(bus.count), 16);
        chk("ovf_wr_ready", int'(bus.wr_ready), 0);
        chk("ovf_flag", int'(bus.overflow), 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_count", int'(bus.count), 0);
        chk("flush_overflow", int'(bus.overflow), 0);
        chk("flush_wr_ready", int'(bus.wr_ready), 1);
        base = rx_q.size();
        man_rdy = 1'b1;
        repeat (30) @(negedge clk);
        chk("flush_no_pulse", rx_q.size(), base);

        // burst of DEPTH bytes into a 20-cycle-busy transmitter
        model_on = 1'b1;
        busy_len = 20;
        base = rx_q.size();
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data = 8'(i);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        chk("burst_count", int'(bus.count), 15);
        chk("burst_wr_ready", int'(bus.wr_ready), 1);
        wait_rx(base + 16, 1000);
        for (int i = 0; i < 16 && base + i < rx_q.size(); i++)
            chk($sformatf("burst_byte%0d", i), int'(rx_q[base+i]), i);
        repeat (40) @(negedge clk);
        chk("burst_extra_pulses", rx_q.size(), base + 16);

        // transmitter that never drops tx_rdy: timeout paces pulses 6 cycles apart
        never_busy = 1'b1;
        base = rx_q.size();
        bus.wr_valid = 1'b1;
        bus.wr_data = 8'hAA;
        @(negedge clk);
        bus.wr_data = 8'hBB;
        @(negedge clk);
        bus.wr_data = 8'hCC;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_rx(base + 3, 100);
        if (rx_q.size() >= base + 3) begin
            chk("to_byte0", int'(rx_q[base]), 8'hAA);
            chk("to_byte1", int'(rx_q[base+1]), 8'hBB);
            chk("to_byte2", int'(rx_q[base+2]), 8'hCC);
            chk("to_gap1", rx_t[base+1] - rx_t[base], 6);
            chk("to_gap2", rx_t[base+2] - rx_t[base+1], 6);
        end
        repeat (10) @(negedge clk);

        // random host valid and random transmitter busy time across pointer wraps
        never_busy = 1'b0;
        rand_busy = 1'b1;
        base = rx_q.size();
        sent = 0;
        for (int i = 0; i < 2000 && sent < 40; i++) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_data = 8'(8'h40 + sent);
            ok_rdy = bus.wr_ready;
            @(negedge clk);
            if (bus.wr_valid && ok_rdy) sent++;
        end
        bus.wr_valid = 1'b0;
        chk("wrap_sent", sent, 40);
        wait_rx(base + 40, 3000);
        for (int i = 0; i < 40 && base + i < rx_q.size(); i++)
            chk($sformatf("wrap_byte%0d", i), int'(rx_q[base+i]), 8'h40 + i);
        repeat (40) @(negedge clk);
        chk("wrap_final_count", int'(bus.count), 0);
        chk("no_back_to_back_en", consec, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
